// File: rtl/cmp_iter_pkg.sv
// rtl/cmp_iter_pkg.sv - shared execute compare types and decode helpers; CMP_MINMAX_EN enables MIN/MAX decode
package cmp_iter_pkg;

  // Encodings of the original six functions are fixed; MIN/MAX family appended above them.
  typedef enum logic [3:0] {
    CMP_EQ   = 4'd0,
    CMP_NE   = 4'd1,
    CMP_LT   = 4'd4,
    CMP_GE   = 4'd5,
    CMP_LTU  = 4'd6,
    CMP_GEU  = 4'd7,
    CMP_MIN  = 4'd8,
    CMP_MAX  = 4'd9,
    CMP_MINU = 4'd10,
    CMP_MAXU = 4'd11
  } e_cmp_function;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } e_cmp_state;

  function automatic logic is_minmax(input e_cmp_function f);
    return f inside {CMP_MIN, CMP_MAX, CMP_MINU, CMP_MAXU};
  endfunction

  // Codes that run the full chunk walk; anything else finishes after one BUSY cycle.
  function automatic logic is_supported(input e_cmp_function f);
    logic base;
    base = f inside {CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};
`ifdef CMP_MINMAX_EN
    return base || is_minmax(f);
`else
    return base;
`endif
  endfunction

  // Functions whose top chunk carries a sign bit.
  function automatic logic is_signed_msb(input e_cmp_function f);
    return f inside {CMP_LT, CMP_GE, CMP_MIN, CMP_MAX};
  endfunction

  // Boolean outcome from the recorded flags; min/max and unknown codes read as 0.
  function automatic logic cmp_res(input e_cmp_function f, input logic eq, input logic lt);
    case (f)
      CMP_EQ:           return eq;
      CMP_NE:           return !eq;
      CMP_LT, CMP_LTU:  return lt;
      CMP_GE, CMP_GEU:  return !lt;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// rtl/cmp_chunk.sv - combinational CHUNK-bit compare with optional two's-complement mode
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_signed,
  output logic             o_eq,
  output logic             o_lt
);

  logic w_sign_diff;

  // Signed operands of opposite sign are ordered by the sign bit alone; otherwise unsigned order holds.
  always_comb begin
    o_eq        = (i_a == i_b);
    w_sign_diff = i_a[CHUNK-1] ^ i_b[CHUNK-1];
    if (i_signed && w_sign_diff) begin
      o_lt = i_a[CHUNK-1];
    end else begin
      o_lt = (i_a < i_b);
    end
  end

endmodule

// File: rtl/cmp_iter.sv
// rtl/cmp_iter.sv - iterative MSB-first chunked comparator; CMP_MINMAX_EN adds the value port and MIN/MAX functions
module cmp_iter
  import cmp_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  e_cmp_function    cmp_function,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res
`ifdef CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] value
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("cmp_iter: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  e_cmp_state      r_state;
  e_cmp_state      w_state_nxt;
  logic [WIDTH-1:0] r_op1;
  logic [WIDTH-1:0] r_op2;
  e_cmp_function   r_func;
  logic [IDXW-1:0] r_idx;
  logic            r_eq;
  logic            r_lt;

  logic             w_accept;
  logic             w_finish;
  logic             w_signed;
  logic             w_eq;
  logic             w_lt;
  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;

`ifdef CMP_MINMAX_EN
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic             w_gt;
`endif

  assign w_a      = r_op1[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b      = r_op2[int'(r_idx)*CHUNK +: CHUNK];
  assign w_signed = (r_idx == IDXW'(NCHUNK-1)) && is_signed_msb(r_func);
  assign w_accept = (r_state == S_IDLE) && in_valid;
  // A differing chunk settles the order; equal chunks run down to chunk 0; unknown codes stop at once.
  assign w_finish = !is_supported(r_func) || !w_eq || (r_idx == '0);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_signed (w_signed),
    .o_eq     (w_eq),
    .o_lt     (w_lt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from the registered state only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_finish) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef CMP_MINMAX_EN
  // Min/max selection on the final chunk outcome; ties pick op2, which equals op1.
  always_comb begin
    w_gt        = !w_eq && !w_lt;
    w_value_nxt = '0;
    case (r_func)
      CMP_MIN, CMP_MINU: w_value_nxt = w_lt ? r_op1 : r_op2;
      CMP_MAX, CMP_MAXU: w_value_nxt = w_gt ? r_op1 : r_op2;
      default:           w_value_nxt = '0;
    endcase
  end
`endif

  // Operand capture at acceptance, chunk walk in BUSY, flag/value capture on the last BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op1   <= '0;
      r_op2   <= '0;
      r_func  <= CMP_EQ;
      r_idx   <= '0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
`ifdef CMP_MINMAX_EN
      r_value <= '0;
`endif
    end else if (w_accept) begin
      r_op1  <= op1;
      r_op2  <= op2;
      r_func <= cmp_function;
      r_idx  <= IDXW'(NCHUNK-1);
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (w_finish) begin
        r_eq    <= w_eq;
        r_lt    <= w_lt;
`ifdef CMP_MINMAX_EN
        r_value <= w_value_nxt;
`endif
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  // Result reads only registers, so it stays fixed for the whole DONE stall.
  assign res = (r_state == S_DONE) && cmp_res(r_func, r_eq, r_lt);
`ifdef CMP_MINMAX_EN
  assign value = r_value;
`endif

endmodule

// File: tb/tb_cmp_iter.sv
// tb/tb_cmp_iter.sv - table-driven and randomized bench for cmp_iter; honours CMP_MINMAX_EN
module tb_cmp_iter;
  import cmp_iter_pkg::*;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;
`ifdef CMP_MINMAX_EN
  localparam int MM_TIE_LAT = 5;
`else
  localparam int MM_TIE_LAT = 2;
`endif

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           hold;
    logic         r;
    logic [W-1:0] v;
    int           lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  e_cmp_function cmp_function = CMP_EQ;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          res;
`ifdef CMP_MINMAX_EN
  logic [W-1:0]  value;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cmp_iter #(.WIDTH(W), .CHUNK(C)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op1          (op1),
    .op2          (op2),
    .cmp_function (cmp_function),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res          (res)
`ifdef CMP_MINMAX_EN
    ,
    .value        (value)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic compare; latency from the count of equal leading bytes.
  function automatic void model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic r, output logic [W-1:0] v, output int lat);
    logic slt, ult, eq, ok;
    int   k;
    slt = $signed(a) < $signed(b);
    ult = a < b;
    eq  = (a == b);
    r = 1'b0; v = '0; ok = 1'b1;
    case (e_cmp_function'(f))
      CMP_EQ:   r = eq;
      CMP_NE:   r = !eq;
      CMP_LT:   r = slt;
      CMP_GE:   r = !slt;
      CMP_LTU:  r = ult;
      CMP_GEU:  r = !ult;
`ifdef CMP_MINMAX_EN
      CMP_MIN:  v = slt ? a : b;
      CMP_MAX:  v = (!slt && !eq) ? a : b;
      CMP_MINU: v = ult ? a : b;
      CMP_MAXU: v = (!ult && !eq) ? a : b;
`endif
      default:  ok = 1'b0;
    endcase
    k = 0;
    for (int i = N-1; i > 0; i--) begin
      if (a[i*C +: C] != b[i*C +: C]) break;
      k++;
    end
    lat = ok ? k + 2 : 2;
  endfunction

  // One transaction: accept, measure latency, stall `hold` cycles with in_valid toggling, then release.
  task automatic run_op(input string tag, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic exp_r, input logic [W-1:0] exp_v, input int exp_lat);
    int lat;
    chk({tag, " in_ready_before"}, W'(in_ready), W'(1));
    cmp_function = e_cmp_function'(f);
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    cmp_function = e_cmp_function'(4'($urandom));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, W'(lat), W'(exp_lat));
    chk({tag, " res"}, W'(res), W'(exp_r));
`ifdef CMP_MINMAX_EN
    chk({tag, " value"}, value, exp_v);
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid;
      op1 = $urandom;
      @(posedge clk); #1;
      chk({tag, " hold out_valid/in_ready"}, W'({out_valid, in_ready}), W'(2'b10));
      chk({tag, " hold res"}, W'(res), W'(exp_r));
`ifdef CMP_MINMAX_EN
      chk({tag, " hold value"}, value, exp_v);
`endif
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk({tag, " released in_ready/out_valid"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  initial begin
    vec_t         tbl[14];
    logic [3:0]   fpool[14];
    logic         mr;
    logic [W-1:0] mv;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           mlat;
    int           seen;
    int           nb;

    tbl[0]  = '{CMP_EQ,   32'h12345678, 32'h12345678, 0, 1'b1, 32'h0, 5};
    tbl[1]  = '{CMP_LT,   32'h80000000, 32'h00000001, 3, 1'b1, 32'h0, 2};
    tbl[2]  = '{CMP_LTU,  32'h80000000, 32'h00000001, 0, 1'b0, 32'h0, 2};
    tbl[3]  = '{CMP_GEU,  32'h000000FF, 32'h00000100, 1, 1'b0, 32'h0, 4};
    tbl[4]  = '{CMP_NE,   32'h00000000, 32'h00000000, 0, 1'b0, 32'h0, 5};
    tbl[5]  = '{CMP_GE,   32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b1, 32'h0, 5};
    tbl[6]  = '{CMP_LT,   32'h7FFFFFFF, 32'h80000000, 0, 1'b0, 32'h0, 2};
    tbl[7]  = '{CMP_LT,   32'h00000100, 32'h000001FF, 0, 1'b1, 32'h0, 5};
    tbl[8]  = '{4'd2,     32'h00000005, 32'h00000005, 0, 1'b0, 32'h0, 2};
    tbl[9]  = '{CMP_MIN,  32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 32'hFFFFFFFF, 2};
    tbl[10] = '{CMP_MINU, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 32'h00000001, 2};
    tbl[11] = '{CMP_MAX,  32'h00000005, 32'h00000005, 1, 1'b0, 32'h00000005, MM_TIE_LAT};
    tbl[12] = '{4'd15,    32'h00000001, 32'h00000002, 0, 1'b0, 32'h0, 2};
    tbl[13] = '{CMP_MAXU, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, 32'hFFFFFFFF, 2};

    fpool = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd2, 4'd3, 4'd12, 4'd15};

    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready/out_valid", W'({in_ready, out_valid}), W'(2'b10));
    chk("reset res", W'(res), W'(0));
`ifdef CMP_MINMAX_EN
    chk("reset value", value, '0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].hold,
             tbl[i].r, tbl[i].v, tbl[i].lat);
    end

    // Reset in cycle 2 of an all-chunks-equal EQ: the operation must vanish.
    cmp_function = CMP_EQ;
    op1 = 32'hCAFEF00D;
    op2 = 32'hCAFEF00D;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy in_ready/out_valid", W'({in_ready, out_valid}), W'(2'b10));
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_busy out_valid count", W'(seen), W'(0));

    for (int t = 0; t < 150; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        rb = $urandom;
      end else begin
        rb = ra;
        nb = $urandom_range(0, N);
        for (int j = 0; j < nb; j++) rb[j*C +: C] = 8'($urandom);
      end
      model(fpool[$urandom_range(0, 13)], ra, rb, mr, mv, mlat);
      begin
        logic [3:0] ff;
        ff = fpool[t % 14];
        model(ff, ra, rb, mr, mv, mlat);
        run_op($sformatf("rnd%0d", t), ff, ra, rb, $urandom_range(0, 2), mr, mv, mlat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/cmp_iter.md
# cmp_iter

Iterative, parametrised comparator for the execute stage: compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and terminates as soon as a chunk differs. It provides the branch and set-less-than compare functions for wide (64-bit and up) datapaths without a full-width single-cycle comparator. It optionally returns a min/max value. It sits behind the issue logic on a valid/ready handshake and feeds the branch-resolve and writeback paths.

## Interface
- WIDTH, 32: operand width in bits.
- CHUNK, 8: bits compared per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1, otherwise elaboration error. NCHUNK = WIDTH/CHUNK.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands and function presented.
- in_ready  out  1  block idle, can accept.
- op1, op2  in  WIDTH  operands.
- cmp_function  in  e_cmp_function  EQ, NE, LT, LTU, GE, GEU; plus MIN, MAX, MINU, MAXU.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- res  out  1  compare outcome; 0 for MIN/MAX/MINU/MAXU and for invalid codes.
- value  out  WIDTH  min/max result, present only with CMP_MINMAX_EN.

## Operation
- FSM states:
  - IDLE: in_ready=1.
    - in_valid & in_ready: latch op1, op2 and function; idx=NCHUNK-1; clear tracking flags; go to BUSY.
  - BUSY: compare chunk idx of both latched operands.
    - Chunk NCHUNK-1 is compared signed for LT, GE, MIN and MAX; all other chunks are compared unsigned.
    - Chunks differ: record lt/gt and go to DONE.
    - Chunks equal and idx==0: record eq and go to DONE.
    - Otherwise: decrement idx and stay in BUSY.
  - DONE: out_valid=1; res and value are registered and held stable.
    - out_ready: go to IDLE.
- Result rules:
  - EQ=eq; NE=!eq; LT/LTU=lt; GE/GEU=!lt.
  - MIN/MINU: value = lt ? op1 : op2.
  - MAX/MAXU: value = gt ? op1 : op2.
  - On a tie, min/max return op2, which equals op1.
- Invalid function code: still takes the handshake, completes after 1 BUSY cycle, res=0, value=0.
- in_valid outside IDLE is ignored. Operands are sampled only at acceptance.
- Reset values: state=IDLE, out_valid=0, res=0, value=0, idx=0, flags cleared. in_ready=1 from the first cycle after the reset edge.
- Reset in any state, including mid-BUSY: return to IDLE; the in-flight operation is discarded and produces no out_valid.

## Timing
- Acceptance in cycle 0.
- k = number of leading equal chunks, capped at NCHUNK-1.
- BUSY occupies cycles 1..k+1; out_valid is asserted in cycle k+2.
- Latency: minimum 2 cycles (first chunk differs), maximum NCHUNK+1 cycles (operands equal).
- in_ready is deasserted from cycle 1 until the cycle after out_valid & out_ready. A new operation can be accepted no earlier than 1 cycle after the result is taken.
- out_valid, res and value do not change while out_valid & !out_ready.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid to out_valid.

## Configuration
- CMP_MINMAX_EN defined:
  - value port, value register and MIN/MAX/MINU/MAXU decoding are present.
- Not defined:
  - value port and value register are absent.
  - MIN/MAX/MINU/MAXU are treated as invalid codes: res=0, 1 BUSY cycle.

## Structure
- The shared execute package holds:
  - e_cmp_function, extended with MIN, MAX, MINU, MAXU; existing encodings are unchanged.
  - The FSM state enum (IDLE, BUSY, DONE).
- One sub-module, cmp_chunk: combinational CHUNK-bit compare with a signed-mode input, producing eq and lt (gt = !eq & !lt). It is instantiated once and driven from idx-selected slices.

## Test plan
All scenarios use WIDTH=32, CHUNK=8, cycles counted from acceptance.
- EQ, 0x12345678 vs 0x12345678 -> res=1, out_valid in cycle 5.
- LT, 0x80000000 vs 0x00000001 -> res=1 in cycle 2. Same operands with LTU -> res=0 in cycle 2.
- GEU, 0x000000FF vs 0x00000100 -> chunks 3 and 2 equal, chunk 1 differs -> res=0, out_valid in cycle 4.
- Backpressure: out_ready held low 3 cycles after out_valid, in_valid toggling -> res stable, in_ready=0, no second operation accepted; next acceptance is 1 cycle after the out_ready handshake.
- Reset: rst_n low in cycle 2 of an EQ on equal operands -> IDLE next cycle, out_valid never asserts, in_ready=1.
- With CMP_MINMAX_EN:
  - MIN, 0xFFFFFFFF vs 0x00000001 -> value=0xFFFFFFFF.
  - MINU, same operands -> value=0x00000001.
  - MAX, 0x5 vs 0x5 -> value=0x5 in cycle 5.
